// File: rtl/nios2_mult_cell_pipe.sv
// Pipelined DATA_WIDTH x DATA_WIDTH integer multiply cell with stall, flush and busy tracking.
// High-word ops (MULXSS/MULXSU/MULXUU) are built only when NIOS2_MULT_CELL_HI_EN is defined.
module nios2_mult_cell_pipe #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned CHUNK_WIDTH = 16,
    parameter int unsigned LATENCY     = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  in_valid,
    input  logic                  in_stall,
    input  logic                  flush,
    input  logic [1:0]            op,
    input  logic [DATA_WIDTH-1:0] src1,
    input  logic [DATA_WIDTH-1:0] src2,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  busy
);

    localparam int unsigned NC  = DATA_WIDTH / CHUNK_WIDTH;
    localparam int unsigned NPP = NC * NC;
    localparam int unsigned PPW = 2 * CHUNK_WIDTH;
`ifdef NIOS2_MULT_CELL_HI_EN
    localparam int unsigned PW  = 2 * DATA_WIDTH;
`else
    localparam int unsigned PW  = DATA_WIDTH;
`endif

    typedef logic [PPW-1:0] pp_t;

    logic                  accept;
    logic                  adv;
    logic                  hi_d;
    pp_t                   pp_d   [NPP];
    pp_t                   red_pp [NPP];
    logic                  red_hi;
    logic                  red_valid;
    logic [PW-1:0]         prod;
    logic [PW-1:0]         fin_prod;
    logic                  fin_hi;
    logic                  fin_valid;
    logic                  s1_busy;
    logic                  dly_busy;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] result_q;

    // Flush wins over stall; nothing moves while stalled.
    assign adv    = !flush && !in_stall;
    assign accept = in_valid && adv;

    // Unsigned chunk partial products; without high ops only the low-half terms are formed.
    always_comb begin
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NC; j++) begin
                pp_d[i*NC+j] = '0;
`ifndef NIOS2_MULT_CELL_HI_EN
                if (i + j < NC)
`endif
                    pp_d[i*NC+j] = PPW'(src1[i*CHUNK_WIDTH +: CHUNK_WIDTH]) *
                                   PPW'(src2[j*CHUNK_WIDTH +: CHUNK_WIDTH]);
            end
        end
    end

`ifdef NIOS2_MULT_CELL_HI_EN
    typedef enum logic [1:0] {
        OpMul    = 2'd0,
        OpMulxss = 2'd1,
        OpMulxsu = 2'd2,
        OpMulxuu = 2'd3
    } op_e;

    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_WIDTH-1:0] corr_d;
    logic [DATA_WIDTH-1:0] red_corr;

    // A signed operand equals its unsigned reading minus 2^W when negative, so the
    // product needs the other operand subtracted from the high word.
    always_comb begin
        sign_a = ((op == OpMulxss) || (op == OpMulxsu)) && src1[DATA_WIDTH-1];
        sign_b = (op == OpMulxss) && src2[DATA_WIDTH-1];
        corr_d = '0;
        if (sign_a) corr_d = corr_d - src2;
        if (sign_b) corr_d = corr_d - src1;
    end

    assign hi_d = (op != OpMul);
`else
    logic unused_op;
    assign unused_op = ^op;
    assign hi_d      = 1'b0;
`endif

    generate
        if (LATENCY == 1) begin : g_comb_front
            always_comb begin
                red_pp    = pp_d;
                red_hi    = hi_d;
                red_valid = accept;
`ifdef NIOS2_MULT_CELL_HI_EN
                red_corr  = corr_d;
`endif
            end
            assign s1_busy = 1'b0;
        end else begin : g_stage1
            pp_t                   pp_q [NPP];
            logic                  s1_valid_q;
            logic                  s1_hi_q;
`ifdef NIOS2_MULT_CELL_HI_EN
            logic [DATA_WIDTH-1:0] corr_q;
`endif

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    s1_valid_q <= 1'b0;
                    s1_hi_q    <= 1'b0;
                    for (int k = 0; k < NPP; k++) pp_q[k] <= '0;
`ifdef NIOS2_MULT_CELL_HI_EN
                    corr_q     <= '0;
`endif
                end else begin
                    if (flush) begin
                        s1_valid_q <= 1'b0;
                    end else if (!in_stall) begin
                        s1_valid_q <= in_valid;
                    end
                    if (accept) begin
                        s1_hi_q <= hi_d;
                        for (int k = 0; k < NPP; k++) pp_q[k] <= pp_d[k];
`ifdef NIOS2_MULT_CELL_HI_EN
                        corr_q  <= corr_d;
`endif
                    end
                end
            end

            always_comb begin
                red_pp    = pp_q;
                red_hi    = s1_hi_q;
                red_valid = s1_valid_q;
`ifdef NIOS2_MULT_CELL_HI_EN
                red_corr  = corr_q;
`endif
            end
            assign s1_busy = s1_valid_q;
        end
    endgenerate

    // Shifted-add reduction of the partial products into the (possibly truncated) product.
    always_comb begin
        prod = '0;
        for (int i = 0; i < NC; i++) begin
            for (int j = 0; j < NC; j++) begin
                prod = prod + (PW'(red_pp[i*NC+j]) << ((i + j) * CHUNK_WIDTH));
            end
        end
`ifdef NIOS2_MULT_CELL_HI_EN
        prod = prod + {red_corr, {DATA_WIDTH{1'b0}}};
`endif
    end

    generate
        if (LATENCY <= 2) begin : g_no_dly
            always_comb begin
                fin_prod  = prod;
                fin_hi    = red_hi;
                fin_valid = red_valid;
            end
            assign dly_busy = 1'b0;
        end else begin : g_dly
            localparam int unsigned Dly = LATENCY - 2;

            logic [PW-1:0]  dly_prod_q [Dly];
            logic [Dly-1:0] dly_hi_q;
            logic [Dly-1:0] dly_valid_q;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    dly_valid_q <= '0;
                    dly_hi_q    <= '0;
                    for (int k = 0; k < Dly; k++) dly_prod_q[k] <= '0;
                end else begin
                    if (flush) begin
                        dly_valid_q <= '0;
                    end else if (!in_stall) begin
                        dly_valid_q[0] <= red_valid;
                        for (int k = 1; k < Dly; k++) dly_valid_q[k] <= dly_valid_q[k-1];
                    end
                    if (adv) begin
                        for (int k = 1; k < Dly; k++) begin
                            if (dly_valid_q[k-1]) begin
                                dly_prod_q[k] <= dly_prod_q[k-1];
                                dly_hi_q[k]   <= dly_hi_q[k-1];
                            end
                        end
                        if (red_valid) begin
                            dly_prod_q[0] <= prod;
                            dly_hi_q[0]   <= red_hi;
                        end
                    end
                end
            end

            always_comb begin
                fin_prod  = dly_prod_q[Dly-1];
                fin_hi    = dly_hi_q[Dly-1];
                fin_valid = dly_valid_q[Dly-1];
            end
            assign dly_busy = |dly_valid_q;
        end
    endgenerate

    // Result only loads with a real operation so it holds across idle and flushed cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            if (flush) begin
                out_valid_q <= 1'b0;
            end else if (!in_stall) begin
                out_valid_q <= fin_valid;
            end
            if (adv && fin_valid) begin
                result_q <= fin_hi ? fin_prod[PW-1 -: DATA_WIDTH] : fin_prod[DATA_WIDTH-1:0];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = s1_busy | dly_busy | out_valid_q;

endmodule

// File: tb/tb_nios2_mult_cell_pipe.sv
// Directed bench for nios2_mult_cell_pipe at default parameters (32/16/2); expected high-op
// words follow whether NIOS2_MULT_CELL_HI_EN is defined for the build.
module tb_nios2_mult_cell_pipe;

`ifdef NIOS2_MULT_CELL_HI_EN
    localparam bit HiBuild = 1'b1;
`else
    localparam bit HiBuild = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_stall;
    logic        flush;
    logic [1:0]  op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        out_valid;
    logic [31:0] result;
    logic        busy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    nios2_mult_cell_pipe #(
        .DATA_WIDTH (32),
        .CHUNK_WIDTH(16),
        .LATENCY    (2)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_valid (in_valid),
        .in_stall (in_stall),
        .flush    (flush),
        .op       (op),
        .src1     (src1),
        .src2     (src2),
        .out_valid(out_valid),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic st, input logic fl);
        in_valid = v;
        op       = o;
        src1     = a;
        src2     = b;
        in_stall = st;
        flush    = fl;
    endtask

    task automatic idle();
        drive(1'b0, 2'd0, 32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] exp;

        vecs[0]  = '{2'd0, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F, 32'h000B_000F};
        vecs[1]  = '{2'd3, 32'h0001_0003, 32'h0002_0005, 32'h0000_0002, 32'h000B_000F};
        vecs[2]  = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
        vecs[3]  = '{2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[4]  = '{2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
        vecs[5]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
        vecs[6]  = '{2'd3, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
        vecs[7]  = '{2'd0, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 32'hFFFE_0001};
        vecs[8]  = '{2'd1, 32'h8000_0000, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[9]  = '{2'd2, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vecs[10] = '{2'd0, 32'h0003_0000, 32'h0000_0007, 32'h0015_0000, 32'h0015_0000};
        vecs[11] = '{2'd0, 32'h0000_0007, 32'h0005_0000, 32'h0023_0000, 32'h0023_0000};
        vecs[12] = '{2'd2, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[13] = '{2'd1, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[14] = '{2'd3, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780};
        vecs[15] = '{2'd3, 32'h0002_0003, 32'h0004_0005, 32'h0000_0008, 32'h0016_000F};

        reset_n = 1'b1;
        idle();
        #1 reset_n = 1'b0;
        #1;
        check("reset out_valid", 32'(out_valid), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        check("reset result", result, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Single ops: latency, pulse width and result hold.
        for (int i = 0; i < 16; i++) begin
            exp = HiBuild ? vecs[i].exp_hi : vecs[i].exp_lo;
            @(negedge clk);
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, 1'b0);
            @(negedge clk);
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h1);
            check($sformatf("vec%0d early valid", i), 32'(out_valid), 32'h0);
            idle();
            @(negedge clk);
            check($sformatf("vec%0d valid", i), 32'(out_valid), 32'h1);
            check($sformatf("vec%0d result", i), result, exp);
            @(negedge clk);
            check($sformatf("vec%0d pulse end", i), 32'(out_valid), 32'h0);
            check($sformatf("vec%0d result hold", i), result, exp);
        end

        // Back-to-back MULs (k, k+1).
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 5) begin
                check($sformatf("b2b c%0d valid", c), 32'(out_valid), 32'h1);
                check($sformatf("b2b c%0d result", c), result, 32'((c - 1) * c));
            end else begin
                check($sformatf("b2b c%0d valid", c), 32'(out_valid), 32'h0);
            end
            if (c < 4) drive(1'b1, 2'd0, 32'(c + 1), 32'(c + 2), 1'b0, 1'b0);
            else idle();
        end

        // Stall in cycles 1-3 delays the result to cycle 5; stalled inputs are ignored.
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h0000_0100, 32'h0000_0300, 1'b0, 1'b0);
        for (int c = 1; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("stall c%0d valid", c), 32'(out_valid), 32'(c == 5));
            if (c == 5) check("stall result", result, 32'h0003_0000);
            if (c == 6) check("stall busy end", 32'(busy), 32'h0);
            if (c <= 3) drive(1'b1, 2'd0, 32'h7, 32'h9, 1'b1, 1'b0);
            else idle();
        end

        // Stall while out_valid is high holds the pulse.
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h0000_1234, 32'h0000_0010, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("hold valid c2", 32'(out_valid), 32'h1);
        check("hold result c2", result, 32'h0001_2340);
        drive(1'b1, 2'd0, 32'h5, 32'h5, 1'b1, 1'b0);
        @(negedge clk);
        check("hold valid c3", 32'(out_valid), 32'h1);
        check("hold result c3", result, 32'h0001_2340);
        idle();
        @(negedge clk);
        check("hold valid c4", 32'(out_valid), 32'h0);
        check("hold busy c4", 32'(busy), 32'h0);

        // Flush with stall and a new op: everything dropped.
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h3, 32'h5, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h6, 32'h7, 1'b0, 1'b0);
        @(negedge clk);
        check("flush pre valid", 32'(out_valid), 32'h1);
        check("flush pre result", result, 32'd15);
        check("flush pre busy", 32'(busy), 32'h1);
        drive(1'b1, 2'd0, 32'h9, 32'h9, 1'b1, 1'b1);
        @(negedge clk);
        check("flush busy", 32'(busy), 32'h0);
        check("flush valid", 32'(out_valid), 32'h0);
        check("flush result hold", result, 32'd15);
        idle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("flush quiet %0d", c), 32'(out_valid), 32'h0);
        end

        // Half-cycle async reset with two ops in flight.
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h11, 32'h11, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 2'd0, 32'h2, 32'h0001_0000, 1'b0, 1'b0);
        @(negedge clk);
        check("rst pre result", result, 32'h121);
        idle();
        reset_n = 1'b0;
        #1;
        check("rst async valid", 32'(out_valid), 32'h0);
        check("rst async busy", 32'(busy), 32'h0);
        check("rst async result", result, 32'h0);
        #3 reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("rst quiet valid %0d", c), 32'(out_valid), 32'h0);
            check($sformatf("rst quiet busy %0d", c), 32'(busy), 32'h0);
        end

        // Operation after reset recovery.
        drive(1'b1, 2'd0, 32'h0000_0009, 32'h0000_000B, 1'b0, 1'b0);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("post rst valid", 32'(out_valid), 32'h1);
        check("post rst result", result, 32'd99);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
